// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-32 hazard scheduler.
//   - opcode constants for the instruction classes the scheduler cares about
//   - ALU operand forwarding select encodings
//   - shadow pipeline entry structs (EX keeps source info, MEM/WB keep only dst)
//   - decode_use_dst(): per-opcode source usage, write-back and load info
package mips_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic              uses_rs;
        logic              uses_rt;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] dst;
    } decode_t;

    typedef struct packed {
        logic              v;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } ex_entry_t;

    typedef struct packed {
        logic              v;
        logic              regwrite;
        logic [REG_AW-1:0] dst;
    } wb_entry_t;

    function automatic decode_t decode_use_dst(input logic [5:0]        opcode,
                                               input logic [REG_AW-1:0] rt,
                                               input logic [REG_AW-1:0] rd);
        decode_t d;
        d = '0;
        case (opcode)
            OP_R: begin
                d.uses_rs  = 1'b1;
                d.uses_rt  = 1'b1;
                d.regwrite = 1'b1;
                d.dst      = rd;
            end
            OP_LW: begin
                d.uses_rs  = 1'b1;
                d.regwrite = 1'b1;
                d.memread  = 1'b1;
                d.dst      = rt;
            end
            OP_SW, OP_BEQ: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
            end
            default: d = '0;
        endcase
        // $0 is hardwired, so writing it never creates a dependency
        if (d.dst == '0) d.regwrite = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   count      : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard control for the 5-stage MIPS-32 core.
// Shadows the EX/MEM/WB destination state and produces, combinationally:
//   pc_write, ifid_write   : PC and IF/ID load enables (low during load-use stall)
//   ifid_flush             : squash IF/ID (taken branch in EX or jump in ID)
//   idex_bubble            : zero ID/EX controls (taken branch or load-use)
//   fwd_a, fwd_b           : ALU operand selects for the instruction in EX
//   stall_cnt, flush_cnt   : saturating perf counters, cleared by cnt_clr
// Inputs: id_valid/id_opcode/id_rs/id_rt/id_rd describe the ID instruction,
// ex_branch_taken flags a taken BEQ resolving in EX.
module hazard_scheduler
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_branch_taken,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_entry_t ex_q, ex_d;
    wb_entry_t mem_q, wb_q;
    decode_t   dec;
    logic      load_use;
    logic      id_jump;
    logic      stall_win;

    assign dec = decode_use_dst(id_opcode, id_rt, id_rd);

    assign load_use = ex_q.v && ex_q.memread && (ex_q.dst != '0) && id_valid &&
                      ((dec.uses_rs && (ex_q.dst == id_rs)) ||
                       (dec.uses_rt && (ex_q.dst == id_rt)));

    assign id_jump = id_valid && (id_opcode == OP_J);

    // A taken branch squashes the ID instruction, so its hazards are moot.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_win   = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_win   = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !idex_bubble) begin
            ex_d.v        = 1'b1;
            ex_d.regwrite = dec.regwrite;
            ex_d.memread  = dec.memread;
            ex_d.dst      = dec.dst;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.uses_rs  = dec.uses_rs;
            ex_d.uses_rt  = dec.uses_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{v: ex_q.v, regwrite: ex_q.regwrite, dst: ex_q.dst};
            wb_q  <= mem_q;
        end
    end

    // EX/MEM is the younger result, so it is checked first.
    function automatic logic [1:0] fwd_sel(input logic              ex_v,
                                           input logic              uses,
                                           input logic [REG_AW-1:0] src,
                                           input wb_entry_t         mem,
                                           input wb_entry_t         wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_v && uses) begin
            if (mem.v && mem.regwrite && (mem.dst != '0) && (mem.dst == src)) begin
                sel = FWD_EXMEM;
            end else if (wb.v && wb.regwrite && (wb.dst != '0) && (wb.dst == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_q.v, ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    assign fwd_b = fwd_sel(ex_q.v, ex_q.uses_rt, ex_q.rt, mem_q, wb_q);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_win),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios plus randomized traffic, all
// checked against an instruction-level reference model of the pipeline.
module tb_hazard_scheduler;

    localparam int CW = 4;
    localparam int CMAX = 15;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] NOP = 6'b001000;

    logic          clk, rst_n;
    logic          id_valid, ex_branch_taken, cnt_clr;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_scheduler #(
        .CNT_W (CW),
        .RA_W  (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .cnt_clr         (cnt_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: instructions in flight ----------------
    typedef struct {
        bit         v;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
    } instr_t;

    instr_t m_ex, m_mem, m_wb, m_id;
    int     m_stall, m_flush;
    bit     e_stall, e_flush, e_bubble;

    function automatic logic [4:0] dst_of(input instr_t i);
        if (!i.v) return 5'd0;
        if (i.op == R) return i.rd;
        if (i.op == LW) return i.rt;
        return 5'd0;
    endfunction

    function automatic bit reads_rs(input logic [5:0] op);
        return (op == R) || (op == LW) || (op == SW) || (op == BEQ);
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return (op == R) || (op == SW) || (op == BEQ);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input bit used);
        if (!m_ex.v || !used || src == 5'd0) return 2'b00;
        if (dst_of(m_mem) == src) return 2'b10;
        if (dst_of(m_wb) == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = '{default: '0};
        m_mem = '{default: '0};
        m_wb = '{default: '0};
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive one ID slot, then check every output against the model.
    task automatic drive_check(input bit v, input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input bit br, input bit clr);
        logic [4:0] ld;
        bit         hz, jmp;
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        ex_branch_taken = br; cnt_clr = clr;
        m_id = '{v: v, op: op, rs: rs, rt: rt, rd: rd};
        ld = (m_ex.v && m_ex.op == LW) ? dst_of(m_ex) : 5'd0;
        hz = v && (ld != 5'd0) &&
             ((reads_rs(op) && rs == ld) || (reads_rt(op) && rt == ld));
        jmp = v && (op == J);
        e_stall  = !br && hz;
        e_flush  = br || (!hz && jmp);
        e_bubble = br || hz;
        #3;
        chk("pc_write", 32'(pc_write), 32'(!e_stall));
        chk("ifid_write", 32'(ifid_write), 32'(!e_stall));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
        chk("fwd_a", 32'(fwd_a), 32'(m_fwd(m_ex.rs, reads_rs(m_ex.op))));
        chk("fwd_b", 32'(fwd_b), 32'(m_fwd(m_ex.rt, reads_rt(m_ex.op))));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic advance();
        @(posedge clk);
        m_wb = m_mem;
        m_mem = m_ex;
        if (e_bubble || !m_id.v) m_ex = '{default: '0};
        else m_ex = m_id;
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_stall && m_stall < CMAX) m_stall++;
            if (e_flush && m_flush < CMAX) m_flush++;
        end
        #1;
    endtask

    task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input bit br, input bit clr);
        drive_check(v, op, rs, rt, rd, br, clr);
        advance();
    endtask

    logic [5:0] ops [6];
    int         stall_before, flush_before;

    initial begin
        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = J; ops[5] = NOP;
        rst_n = 1'b0;
        id_valid = 1'b1; id_opcode = R; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        ex_branch_taken = 1'b0; cnt_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_idex_bubble", 32'(idex_bubble), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;

        // LW $2,0($1) ; ADD $3,$2,$4
        step(1, LW, 5'd1, 5'd2, 5'd0, 0, 0);
        drive_check(1, R, 5'd2, 5'd4, 5'd3, 0, 0);
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        advance();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step(1, R, 5'd2, 5'd4, 5'd3, 0, 0);
        drive_check(1, NOP, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("lu_fwd_a_memwb", 32'(fwd_a), 32'b01);
        advance();

        // ADD $5,$1,$2 ; ADD $5,$5,$3 ; SUB $6,$5,$5
        step(1, R, 5'd1, 5'd2, 5'd5, 0, 0);
        step(1, R, 5'd5, 5'd3, 5'd5, 0, 0);
        step(1, R, 5'd5, 5'd5, 5'd6, 0, 0);
        drive_check(1, NOP, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("dbl_fwd_a", 32'(fwd_a), 32'b10);
        chk("dbl_fwd_b", 32'(fwd_b), 32'b10);
        advance();

        // LW $0 ; ADD $3,$0,$0 ; ADD $7 ; SW $7
        step(1, LW, 5'd1, 5'd0, 5'd0, 0, 0);
        drive_check(1, R, 5'd0, 5'd0, 5'd3, 0, 0);
        chk("r0_no_stall", 32'(pc_write), 32'd1);
        advance();
        step(1, R, 5'd1, 5'd2, 5'd7, 0, 0);
        chk("r0_fwd_a", 32'(fwd_a), 32'b00);
        step(1, SW, 5'd1, 5'd7, 5'd0, 0, 0);
        drive_check(1, NOP, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("sw_fwd_b", 32'(fwd_b), 32'b10);
        advance();

        // Taken branch overrides a load-use stall
        step(1, LW, 5'd1, 5'd2, 5'd0, 0, 0);
        stall_before = m_stall;
        flush_before = m_flush;
        drive_check(1, R, 5'd2, 5'd4, 5'd3, 1, 0);
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        advance();
        chk("br_stall_same", 32'(stall_cnt), 32'(stall_before));
        chk("br_flush_inc", 32'(flush_cnt), 32'(flush_before + 1));

        // Jump: one-cycle flush, jump itself not bubbled
        drive_check(1, J, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("j_flush", 32'(ifid_flush), 32'd1);
        chk("j_bubble", 32'(idex_bubble), 32'd0);
        advance();
        drive_check(0, NOP, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("j_flush_done", 32'(ifid_flush), 32'd0);
        advance();

        // Random traffic, small register range for frequent collisions
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 85, ops[$urandom_range(0, 5)],
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
        end

        // Saturation: 20 load-use stalls into a 4-bit counter
        step(0, NOP, 5'd0, 5'd0, 5'd0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, LW, 5'd1, 5'd2, 5'd0, 0, 0);
            step(1, R, 5'd2, 5'd4, 5'd3, 0, 0);
        end
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        step(0, NOP, 5'd0, 5'd0, 5'd0, 0, 1);
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);

        // Reset asserted in the middle of a stall cycle
        step(1, LW, 5'd1, 5'd2, 5'd0, 0, 0);
        drive_check(1, R, 5'd2, 5'd4, 5'd3, 0, 0);
        chk("pre_rst_stall", 32'(pc_write), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc_write", 32'(pc_write), 32'd1);
        chk("mid_rst_ifid_write", 32'(ifid_write), 32'd1);
        chk("mid_rst_bubble", 32'(idex_bubble), 32'd0);
        chk("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, R, 5'd2, 5'd4, 5'd3, 0, 0);
        step(1, NOP, 5'd0, 5'd0, 5'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the 5-stage MIPS-32 core.
- Keeps a shadow copy of the EX/MEM/WB destination-register state and sequences the pipeline: load-use stalls, branch/jump flushes, and EX-stage forwarding selects.
- Sits beside the decode control unit. Drives PC/IF-ID write enables, the ID/EX bubble mux and the ALU operand muxes.
- Holds saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16: width of the stall and flush event counters.
- RA_W, 5: register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  6  opcode in ID.
- id_rs  in  RA_W  rs field in ID.
- id_rt  in  RA_W  rt field in ID.
- id_rd  in  RA_W  rd field in ID.
- ex_branch_taken  in  1  BEQ in EX resolved taken this cycle.
- cnt_clr  in  1  synchronous counter clear.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a bubble at the next edge.
- idex_bubble  out  1  ID/EX loads all-zero controls at the next edge.
- fwd_a  out  2  ALU A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  ALU B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  cycles with ifid_flush asserted.

Behaviour:
- Decode rules:
  - Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010; all others are NOP.
  - uses_rs: R, LW, SW, BEQ. uses_rt: R, SW, BEQ.
  - dst: R gives rd, LW gives rt, others give none. A dst of 0 counts as none.
- Shadow registers:
  - EX stage: {v, regwrite, memread, dst, rs, rt, uses_rs, uses_rt}.
  - MEM stage: {v, regwrite, dst}. WB stage: {v, regwrite, dst}.
  - At every posedge: WB<=MEM, MEM<=EX, and EX<=decoded ID, or invalid when idex_bubble=1 or id_valid=0.
- All control outputs are combinational from the shadow state plus the ID inputs, with zero latency.
- load_use = EX.v & EX.memread & EX.dst!=0 & id_valid & ((uses_rs & EX.dst==id_rs) | (uses_rt & EX.dst==id_rt)).
- Priority 1, ex_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Any load_use or jump in ID is ignored (the squashed instruction has no effect).
- Priority 2, load_use: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. The stall lasts exactly one cycle, because the load moves to MEM and MEM/WB forwarding covers the dependency.
- Priority 3, id_valid & opcode J: ifid_flush=1, idex_bubble=0 (the jump itself proceeds), PC enabled.
- Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Forwarding, computed for the EX instruction:
  - fwd_a=10 if MEM.v & MEM.regwrite & MEM.dst!=0 & MEM.dst==EX.rs & EX.uses_rs.
  - Else fwd_a=01 under the same condition using WB.
  - Else fwd_a=00.
  - fwd_b is the same, using EX.rt and EX.uses_rt.
  - EX/MEM always wins over MEM/WB. An invalid EX entry gives 00.
- Counters:
  - stall_cnt increments in each cycle where load_use wins.
  - flush_cnt increments in each cycle where ifid_flush=1.
  - Both saturate at all-ones. cnt_clr forces 0 and takes priority over increment.
- Reset, asynchronous, in any state including mid-stall: all shadow v=0 and counters=0. The combinational outputs then settle to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00. The instruction in ID is re-evaluated cleanly after rst_n rises.

Decomposition:
- Package mips_pkg holds:
  - the opcode localparams;
  - the fwd_sel encodings FWD_RF/FWD_EXMEM/FWD_MEMWB;
  - a shadow-entry struct typedef;
  - the function decode_use_dst(opcode, rt, rd) returning {uses_rs, uses_rt, regwrite, memread, dst}.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- LW $2 <- 0($1) followed by ADD $3,$2,$4 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Next cycle fwd_a=01. stall_cnt=1.
- ADD $5,$1,$2; ADD $5,$5,$3; SUB $6,$5,$5 -> third instruction in EX gets fwd_a=fwd_b=10 (the EX/MEM value wins over MEM/WB). No stall.
- LW $0 <- 0($1) followed by ADD $3,$0,$0 -> no stall, fwd=00. ADD $7 followed by SW $7 -> fwd_b=10.
- ex_branch_taken=1 while ID holds a load-use-dependent ADD -> ifid_flush=1, idex_bubble=1, pc_write=1. stall_cnt is unchanged and flush_cnt increments by 1.
- J in ID -> ifid_flush=1 for exactly 1 cycle and idex_bubble=0. The next ID slot is invalid.
- With CNT_W=4: drive 20 load-use stalls -> stall_cnt=15. cnt_clr -> 0. Assert rst_n=0 during a stall cycle -> outputs at reset values immediately and counters at 0.
